// File: rtl/sa_result_writeback_if.sv
// Write-side bus from the result writeback stage to the output SRAM writer.
//   wr_valid : beat valid (master -> slave)
//   wr_ready : beat accepted (slave -> master)
//   wr_addr  : SRAM word address of the beat
//   wr_data  : one packed result row
//   wr_last  : final row of a tile
interface sa_result_writeback_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  wr_last,
        output wr_ready
    );
endinterface

// File: rtl/sa_result_writeback.sv
// Result writeback stage for the systolic array. Captures a saturated int8 result tile when
// res_valid pulses and streams it one row per beat to the SRAM writer, generating row addresses
// from the base/stride sampled with the tile. Two tile slots form a FIFO so the next tile can be
// accepted while the current one drains.
//   clk, reset_n        : clock, asynchronous active-low reset
//   res_valid/res_ready : tile capture handshake; res_in is the tile, res_base_addr and
//                         res_row_stride give the row address pattern
//   wr                  : write bus (master side)
//   tile_done           : one-cycle pulse after the last row of a tile is accepted
//   overrun/clr_overrun : sticky dropped-tile flag and its synchronous clear
module sa_result_writeback #(
    parameter int unsigned BM_NUM = 4,
    parameter int unsigned BN_NUM = 4,
    parameter int unsigned BW_ACT = 8,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     res_valid,
    input  logic signed [BW_ACT-1:0] res_in [BM_NUM][BN_NUM],
    input  logic        [ADDR_W-1:0] res_base_addr,
    input  logic        [ADDR_W-1:0] res_row_stride,
    output logic                     res_ready,
    sa_result_writeback_if.master    wr,
    output logic                     tile_done,
    output logic                     overrun,
    input  logic                     clr_overrun
);
    localparam int unsigned RowW  = (BM_NUM > 1) ? $clog2(BM_NUM) : 1;
    localparam int unsigned DataW = BN_NUM * BW_ACT;
    localparam logic [RowW-1:0] LastRow = RowW'(BM_NUM - 1);

    typedef enum logic {StIdle, StDrain} state_e;

    state_e            state_q, state_d;
    logic [1:0]        count_q, count_d;
    logic              head_q, head_d;
    logic [RowW-1:0]   row_q, row_d;
    logic              tile_done_q;
    logic              overrun_q, overrun_d;

    logic [DataW-1:0]  slot_data_q   [2][BM_NUM];
    logic [ADDR_W-1:0] slot_base_q   [2];
    logic [ADDR_W-1:0] slot_stride_q [2];

    logic [DataW-1:0]  res_packed [BM_NUM];
    logic              valid, last, hs, pop, push, drop, tail;

    // Element j of a row lands in bits [(j+1)*BW_ACT-1 : j*BW_ACT].
    always_comb begin
        for (int r = 0; r < BM_NUM; r++) begin
            res_packed[r] = '0;
            for (int j = 0; j < BN_NUM; j++) begin
                res_packed[r][j*BW_ACT +: BW_ACT] = res_in[r][j];
            end
        end
    end

    always_comb begin
        // StDrain is held exactly while count_q != 0.
        valid = (state_q == StDrain);
        last  = (row_q == LastRow);

        // Outputs read zero when idle so nothing stale is presented.
        wr.wr_valid = valid;
        wr.wr_last  = valid & last;
        wr.wr_addr  = '0;
        wr.wr_data  = '0;
        if (valid) begin
            wr.wr_addr = slot_base_q[head_q] + ADDR_W'(row_q) * slot_stride_q[head_q];
            wr.wr_data = slot_data_q[head_q][row_q];
        end

        hs  = valid & wr.wr_ready;
        pop = hs & last;

        // A full FIFO still accepts when the head slot retires in this same cycle.
        res_ready = (count_q < 2'd2) | ((count_q == 2'd2) & pop);
        push      = res_valid & res_ready;
        drop      = res_valid & ~res_ready;

        // Next free slot; with count 2 and a pop this is the slot being vacated.
        tail = head_q ^ count_q[0];

        count_d = count_q + {1'b0, push} - {1'b0, pop};
        head_d  = head_q ^ pop;

        row_d = row_q;
        if (hs) begin
            row_d = last ? '0 : row_q + 1'b1;
        end

        // Drop wins over a coincident clear.
        overrun_d = drop | (overrun_q & ~clr_overrun);

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (push) state_d = StDrain;
            StDrain: if (count_d == 2'd0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            count_q     <= 2'd0;
            head_q      <= 1'b0;
            row_q       <= '0;
            tile_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            head_q      <= head_d;
            row_q       <= row_d;
            tile_done_q <= pop;
            overrun_q   <= overrun_d;
        end
    end

    // Slot payload needs no reset: it is only visible while its slot is occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_data_q[tail]   <= res_packed;
            slot_base_q[tail]   <= res_base_addr;
            slot_stride_q[tail] <= res_row_stride;
        end
    end

    assign tile_done = tile_done_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_sa_result_writeback.sv
// Directed testbench for sa_result_writeback: single tile, backpressure, back-to-back tiles,
// overrun, full-with-pop capture, address wrap and asynchronous reset mid-drain.
module tb_sa_result_writeback;
    logic              clk = 1'b0;
    logic              reset_n;
    logic              res_valid;
    logic signed [7:0] res_in [4][4];
    logic [11:0]       res_base_addr;
    logic [11:0]       res_row_stride;
    logic              res_ready;
    logic              tile_done;
    logic              overrun;
    logic              clr_overrun;

    int tests = 0;
    int fails = 0;
    int row_i;
    int cyc;
    logic [3:0]  bp_pat = 4'b1001;
    logic [11:0] wrap_addr [4] = '{12'hFFC, 12'h000, 12'h004, 12'h008};

    always #5 clk = ~clk;

    sa_result_writeback_if #(.ADDR_W(12), .DATA_W(32)) wr_if ();

    sa_result_writeback #(
        .BM_NUM(4),
        .BN_NUM(4),
        .BW_ACT(8),
        .ADDR_W(12)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .res_valid      (res_valid),
        .res_in         (res_in),
        .res_base_addr  (res_base_addr),
        .res_row_stride (res_row_stride),
        .res_ready      (res_ready),
        .wr             (wr_if),
        .tile_done      (tile_done),
        .overrun        (overrun),
        .clr_overrun    (clr_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tile k, element [r][j] = k*0x40 + 16*r + j (8-bit); k >= 2 gives negative values.
    task automatic load_tile(input int k);
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                res_in[r][j] = 8'(k * 64 + 16 * r + j);
            end
        end
    endtask

    function automatic logic [31:0] row_word(input int k, input int r);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) begin
            w[j*8 +: 8] = 8'(k * 64 + 16 * r + j);
        end
        return w;
    endfunction

    task automatic expect_beat(input string tag, input logic [11:0] a, input logic [31:0] d,
                               input logic l);
        check({tag, "_valid"}, {31'd0, wr_if.wr_valid}, 32'd1);
        check({tag, "_addr"}, {20'd0, wr_if.wr_addr}, {20'd0, a});
        check({tag, "_data"}, wr_if.wr_data, d);
        check({tag, "_last"}, {31'd0, wr_if.wr_last}, {31'd0, l});
    endtask

    initial begin
        res_valid       = 1'b0;
        wr_if.wr_ready  = 1'b0;
        clr_overrun     = 1'b0;
        res_base_addr   = '0;
        res_row_stride  = '0;
        load_tile(0);
        reset_n         = 1'b0;
        #12;
        check("rst_res_ready", {31'd0, res_ready}, 32'd1);
        check("rst_wr_valid", {31'd0, wr_if.wr_valid}, 32'd0);
        check("rst_wr_addr", {20'd0, wr_if.wr_addr}, 32'd0);
        check("rst_wr_data", wr_if.wr_data, 32'd0);
        check("rst_wr_last", {31'd0, wr_if.wr_last}, 32'd0);
        check("rst_tile_done", {31'd0, tile_done}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single tile
        @(negedge clk);
        load_tile(0);
        res_base_addr  = 12'h100;
        res_row_stride = 12'h004;
        res_valid      = 1'b1;
        wr_if.wr_ready = 1'b1;
        #1;
        check("single_res_ready", {31'd0, res_ready}, 32'd1);
        check("single_idle_valid", {31'd0, wr_if.wr_valid}, 32'd0);
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            res_valid = 1'b0;
            #1;
            expect_beat("single", 12'(12'h100 + 4 * r), row_word(0, r), r == 3);
            check("single_td_low", {31'd0, tile_done}, 32'd0);
            if (r == 0) check("single_b0_literal", wr_if.wr_data, 32'h03020100);
        end
        @(negedge clk);
        #1;
        check("single_tile_done", {31'd0, tile_done}, 32'd1);
        check("single_drained", {31'd0, wr_if.wr_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("single_td_pulse", {31'd0, tile_done}, 32'd0);

        // Backpressure with wr_ready pattern 1,0,0,1,...
        @(negedge clk);
        load_tile(1);
        res_base_addr  = 12'h200;
        res_row_stride = 12'h010;
        res_valid      = 1'b1;
        wr_if.wr_ready = 1'b0;
        row_i = 0;
        cyc   = 0;
        while (row_i < 4 && cyc < 24) begin
            @(negedge clk);
            res_valid      = 1'b0;
            wr_if.wr_ready = bp_pat[cyc % 4];
            #1;
            expect_beat("bp", 12'(12'h200 + 16 * row_i), row_word(1, row_i), row_i == 3);
            if (wr_if.wr_ready) row_i++;
            cyc++;
        end
        check("bp_rows", row_i, 32'd4);
        @(negedge clk);
        wr_if.wr_ready = 1'b1;
        #1;
        check("bp_tile_done", {31'd0, tile_done}, 32'd1);
        check("bp_drained", {31'd0, wr_if.wr_valid}, 32'd0);

        // Back-to-back tiles
        @(negedge clk);
        load_tile(2);
        res_base_addr  = 12'h300;
        res_row_stride = 12'h008;
        res_valid      = 1'b1;
        @(negedge clk);
        load_tile(3);
        res_base_addr  = 12'h040;
        res_row_stride = 12'h020;
        #1;
        check("b2b_res_ready", {31'd0, res_ready}, 32'd1);
        expect_beat("b2b_t0", 12'h300, row_word(2, 0), 1'b0);
        check("b2b_neg_literal", wr_if.wr_data, 32'h83828180);
        for (int r = 1; r < 4; r++) begin
            @(negedge clk);
            res_valid = 1'b0;
            #1;
            expect_beat("b2b_t0", 12'(12'h300 + 8 * r), row_word(2, r), r == 3);
        end
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            #1;
            expect_beat("b2b_t1", 12'(12'h040 + 32 * r), row_word(3, r), r == 3);
            check("b2b_td", {31'd0, tile_done}, (r == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        #1;
        check("b2b_td2", {31'd0, tile_done}, 32'd1);
        check("b2b_drained", {31'd0, wr_if.wr_valid}, 32'd0);

        // Overrun: three tiles while stalled
        @(negedge clk);
        wr_if.wr_ready = 1'b0;
        load_tile(1);
        res_base_addr  = 12'h010;
        res_row_stride = 12'h001;
        res_valid      = 1'b1;
        #1;
        check("ovr_rdy0", {31'd0, res_ready}, 32'd1);
        @(negedge clk);
        load_tile(2);
        res_base_addr  = 12'h020;
        res_row_stride = 12'h002;
        #1;
        check("ovr_rdy1", {31'd0, res_ready}, 32'd1);
        @(negedge clk);
        load_tile(3);
        res_base_addr  = 12'h7F0;
        res_row_stride = 12'h003;
        #1;
        check("ovr_rdy2", {31'd0, res_ready}, 32'd0);
        check("ovr_not_yet", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        res_valid = 1'b0;
        #1;
        check("ovr_set", {31'd0, overrun}, 32'd1);
        check("ovr_rdy_low", {31'd0, res_ready}, 32'd0);
        expect_beat("ovr_stall", 12'h010, row_word(1, 0), 1'b0);
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            wr_if.wr_ready = 1'b1;
            #1;
            expect_beat("ovr_a", 12'(12'h010 + r), row_word(1, r), r == 3);
        end
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            #1;
            expect_beat("ovr_b", 12'(12'h020 + 2 * r), row_word(2, r), r == 3);
            if (r == 0) check("ovr_td", {31'd0, tile_done}, 32'd1);
        end
        @(negedge clk);
        #1;
        check("ovr_drained", {31'd0, wr_if.wr_valid}, 32'd0);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        @(negedge clk);
        clr_overrun = 1'b1;
        #1;
        check("ovr_clr_sync", {31'd0, overrun}, 32'd1);
        @(negedge clk);
        clr_overrun = 1'b0;
        #1;
        check("ovr_cleared", {31'd0, overrun}, 32'd0);

        // Full FIFO with capture on the wr_last handshake
        @(negedge clk);
        wr_if.wr_ready = 1'b0;
        load_tile(0);
        res_base_addr  = 12'h400;
        res_row_stride = 12'h004;
        res_valid      = 1'b1;
        @(negedge clk);
        load_tile(1);
        res_base_addr  = 12'h500;
        @(negedge clk);
        res_valid = 1'b0;
        #1;
        check("full_rdy_low", {31'd0, res_ready}, 32'd0);
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            wr_if.wr_ready = 1'b1;
            #1;
            expect_beat("full_a", 12'(12'h400 + 4 * r), row_word(0, r), 1'b0);
        end
        @(negedge clk);
        load_tile(2);
        res_base_addr  = 12'h600;
        res_row_stride = 12'h001;
        res_valid      = 1'b1;
        #1;
        expect_beat("full_a_last", 12'h40C, row_word(0, 3), 1'b1);
        check("full_pop_rdy", {31'd0, res_ready}, 32'd1);
        @(negedge clk);
        res_valid      = 1'b0;
        wr_if.wr_ready = 1'b0;
        #1;
        check("full_no_overrun", {31'd0, overrun}, 32'd0);
        check("full_count2", {31'd0, res_ready}, 32'd0);
        check("full_td", {31'd0, tile_done}, 32'd1);
        expect_beat("full_b_head", 12'h500, row_word(1, 0), 1'b0);
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            wr_if.wr_ready = 1'b1;
            #1;
            expect_beat("full_b", 12'(12'h500 + 4 * r), row_word(1, r), r == 3);
        end
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            #1;
            expect_beat("full_c", 12'(12'h600 + r), row_word(2, r), r == 3);
        end
        @(negedge clk);
        #1;
        check("full_drained", {31'd0, wr_if.wr_valid}, 32'd0);

        // Address wrap
        @(negedge clk);
        load_tile(0);
        res_base_addr  = 12'hFFC;
        res_row_stride = 12'h004;
        res_valid      = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            res_valid = 1'b0;
            #1;
            expect_beat("wrap", wrap_addr[r], row_word(0, r), r == 3);
        end
        @(negedge clk);
        #1;
        check("wrap_td", {31'd0, tile_done}, 32'd1);

        // Reset mid-drain
        @(negedge clk);
        load_tile(1);
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        #1;
        expect_beat("rstd_b0", 12'hFFC, row_word(1, 0), 1'b0);
        @(negedge clk);
        #1;
        expect_beat("rstd_b1", 12'h000, row_word(1, 1), 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check("rstd_valid_drop", {31'd0, wr_if.wr_valid}, 32'd0);
        check("rstd_addr", {20'd0, wr_if.wr_addr}, 32'd0);
        check("rstd_res_ready", {31'd0, res_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("rstd_quiet_valid", {31'd0, wr_if.wr_valid}, 32'd0);
            check("rstd_quiet_td", {31'd0, tile_done}, 32'd0);
            check("rstd_quiet_rdy", {31'd0, res_ready}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sa_result_writeback.md
# sa_result_writeback

Downstream writeback stage for the systolic array. It captures the saturated int8 result tile (BM_NUM x BN_NUM) when the array controller pulses `res_valid`. It then streams the tile one row per beat into the output SRAM writer over a valid/ready interface, generating the row addresses itself. A two-entry tile buffer lets the array deliver the next tile while the current one is still draining.

## Interface
- BM_NUM, 4: result rows per tile; one write beat per row.
- BN_NUM, 4: result columns per row; packed into one beat.
- BW_ACT, 8: bit width of each result element.
- ADDR_W, 12: width of the SRAM word address.

- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- res_valid  in  1  one-cycle pulse: `res_in` holds a complete tile to capture.
- res_in  in  [BM_NUM][BN_NUM] x BW_ACT signed  result tile from the array.
- res_base_addr  in  ADDR_W  address of row 0; sampled with `res_valid`.
- res_row_stride  in  ADDR_W  address increment per row; sampled with `res_valid`.
- res_ready  out  1  high when a `res_valid` in this cycle will be captured.
- wr_valid  out  1  write beat valid.
- wr_ready  in  1  SRAM writer accepts the beat.
- wr_addr  out  ADDR_W  beat address.
- wr_data  out  BN_NUM*BW_ACT  packed row.
- wr_last  out  1  marks the final row of a tile.
- tile_done  out  1  one-cycle pulse after a tile fully drains.
- overrun  out  1  sticky: a tile was dropped.
- clr_overrun  in  1  synchronous clear of `overrun`.

## Operation
- **Storage:** two tile slots, each holding data, base address and stride, managed as a FIFO. `count` ranges 0..2. The head slot is the one draining.
- **Row counter:** `row` runs 0..BM_NUM-1 and indexes the head slot.
- **Beat contents:**
  - `wr_data[(j+1)*BW_ACT-1 : j*BW_ACT] = slot[row][j]`.
  - `wr_addr = base + row*stride`, truncated to ADDR_W bits (wraps modulo 2^ADDR_W).
  - `wr_last = (row == BM_NUM-1)`.
- **States:**
  - IDLE (`count == 0`): goes to DRAIN when a capture occurs.
  - DRAIN: each handshake (`wr_valid & wr_ready`) increments `row`.
  - On the handshake with `row == BM_NUM-1`: `row` returns to 0, the head slot is popped, and `tile_done` pulses. The block stays in DRAIN if `count` is still non-zero after the pop and capture; otherwise it returns to IDLE.
- **Capture condition:**
  - `res_ready = (count < 2) | (count == 2 & wr_valid & wr_ready & wr_last)`.
  - A simultaneous pop and push is legal, and then `count` is unchanged.
- **Drop on full:** `res_valid` while `res_ready` is low drops the tile and sets `overrun`. Stored slots are left unmodified.
- **Overrun flag:** `clr_overrun` clears `overrun`. If a drop and `clr_overrun` occur in the same cycle, the set wins.
- **Handshake stability:** `wr_valid = (count != 0)`. While `wr_valid & !wr_ready`, `wr_addr`, `wr_data` and `wr_last` hold stable.
- **No arithmetic on data:** data passes through bit-exact. Signedness matters only for packing.

## Timing
- **Reset values:** `count=0`, `row=0`, `wr_valid=0`, `wr_addr=0`, `wr_data=0`, `wr_last=0`, `tile_done=0`, `overrun=0`, `res_ready=1`.
- **Capture latency:** a capture at edge t (from IDLE) gives `wr_valid=1` with row 0 in cycle t+1.
- **Throughput:** with `wr_ready` held high, a tile drains in BM_NUM cycles. Back-to-back tiles have no bubble: the next tile's row 0 appears in the cycle after the `wr_last` handshake.
- **tile_done:** registered; high in the cycle after the `wr_last` handshake edge, for exactly one cycle.
- **Stalls:** `wr_ready` low stalls indefinitely, with no timeout.
- **res_ready:** combinational from `count` and the current handshake.
- **Reset mid-drain:** asynchronously discards both slots; `wr_valid` drops immediately. There is no partial-tile completion and no `tile_done` pulse.

## Test plan
- **Single tile:** `res_in[r][j] = 16*r + j`, base=0x100, stride=4, `wr_ready=1`.
  - Expect 4 beats, addresses 0x100/0x104/0x108/0x10C.
  - Beat 0 data = 0x03020100; `wr_last` on beat 3.
  - `tile_done` high one cycle later.
- **Backpressure:** toggle `wr_ready` 1,0,0,1,…
  - Data and address stay stable while stalled.
  - Each row is emitted exactly once, in order.
- **Back-to-back tiles:** two `res_valid` pulses 1 cycle apart, `wr_ready=1`.
  - 8 contiguous beats with no bubble.
  - Second tile uses its own base and stride; `tile_done` pulses twice.
- **Overrun:**
  - Set `wr_ready=0` and send 3 tiles. The third is dropped: `overrun=1`, `res_ready` stays 0.
  - Release `wr_ready`: tiles 1 and 2 drain intact.
  - `clr_overrun` returns `overrun` to 0.
- **Full with simultaneous pop:** `count=2` and `res_valid` coincides with the `wr_last` handshake.
  - Tile is captured, `overrun` stays 0, `count` remains 2.
- **Address wrap and reset:**
  - base=0xFFC, stride=4 (ADDR_W=12): addresses 0xFFC, 0x000, 0x004, 0x008.
  - Assert `reset_n=0` after beat 1: `wr_valid=0` immediately.
  - After release: `res_ready=1`, and no further beats or `tile_done` occur.
